// File: rtl/rv_rr_issue_arbiter_pkg.sv
// Shared types and helpers for the round-robin issue arbiter.
// Helpers work on a fixed maximum width; callers zero-pad narrower vectors.
package rv_rr_issue_arbiter_pkg;

  localparam int MAX_REQS = 64;

  typedef enum logic {
    ARB_ST_ARB    = 1'b0,
    ARB_ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int onehot_to_index(input logic [MAX_REQS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Priority encoder: index of the lowest set bit, 0 when none is set.
  function automatic int lowest_set(input logic [MAX_REQS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_REQS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rv_rr_issue_arbiter_if.sv
// Request side and grant side of the issue arbiter, bundled as one interface.
// Handshake: a beat moves on a cycle where both its valid and its ready are high.
interface rv_rr_issue_arbiter_if #(
  parameter int NUM_REQS = 8
);
  localparam int IDX_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0] req_valid;
  logic [NUM_REQS-1:0] req_last;
  logic [NUM_REQS-1:0] req_ready;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_index;
  logic [NUM_REQS-1:0] grant_onehot;
  logic                grant_last;
  logic                grant_ready;
  logic                locked;

  modport master (
    output req_valid, req_last, grant_ready,
    input  req_ready, grant_valid, grant_index, grant_onehot, grant_last, locked
  );

  modport slave (
    input  req_valid, req_last, grant_ready,
    output req_ready, grant_valid, grant_index, grant_onehot, grant_last, locked
  );
endinterface

// File: rtl/rv_rr_mask.sv
// Thermometer mask of the bits strictly above a one-hot pointer,
// built as a log-depth prefix-OR scan (low to high) then shifted up one.
module rv_rr_mask #(
  parameter int NUM_REQS = 8
) (
  input  logic [NUM_REQS-1:0] onehot_i,
  output logic [NUM_REQS-1:0] mask_o
);
  localparam int STAGES = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0] scan [STAGES+1];

  assign scan[0] = onehot_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_scan
    assign scan[k+1] = scan[k] | (scan[k] << (2 ** k));
  end

  assign mask_o = scan[STAGES] << 1;
endmodule

// File: rtl/rv_rr_issue_arbiter.sv
// Round-robin arbiter sharing one registered issue slot among NUM_REQS requesters,
// with an optional lock that holds the slot for one requester until req_last.
module rv_rr_issue_arbiter
  import rv_rr_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQS = 8,
  parameter bit LOCK_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  rv_rr_issue_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQS);

  arb_state_e          state_q, state_d;
  logic [NUM_REQS-1:0] ptr_oh_q;
  logic                grant_valid_q;
  logic [IDX_W-1:0]    grant_index_q;
  logic [NUM_REQS-1:0] grant_onehot_q;
  logic                grant_last_q;

  logic [NUM_REQS-1:0] mask;
  logic [NUM_REQS-1:0] masked;
  logic [MAX_REQS-1:0] req_pad, masked_pad, ptr_pad;
  logic [IDX_W-1:0]    lock_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [NUM_REQS-1:0] cand_oh;
  logic                cand_vld;
  logic                slot_free;
  logic                fire;

  rv_rr_mask #(.NUM_REQS(NUM_REQS)) u_mask (
    .onehot_i (ptr_oh_q),
    .mask_o   (mask)
  );

  assign masked    = bus.req_valid & mask;
  assign slot_free = !grant_valid_q || bus.grant_ready;

  always_comb begin
    req_pad    = '0;
    masked_pad = '0;
    ptr_pad    = '0;
    req_pad[NUM_REQS-1:0]    = bus.req_valid;
    masked_pad[NUM_REQS-1:0] = masked;
    ptr_pad[NUM_REQS-1:0]    = ptr_oh_q;
    // While locked, the last winner is by construction the lock owner.
    lock_idx = IDX_W'(onehot_to_index(ptr_pad));
    if (state_q == ARB_ST_LOCKED) begin
      cand_idx = lock_idx;
      cand_vld = bus.req_valid[lock_idx];
    end else begin
      cand_vld = |bus.req_valid;
      cand_idx = (|masked) ? IDX_W'(lowest_set(masked_pad)) : IDX_W'(lowest_set(req_pad));
    end
  end

  // Gating with reset keeps requesters from seeing a phantom consume while held in reset.
  assign fire    = slot_free && cand_vld && reset;
  assign cand_oh = NUM_REQS'(1) << cand_idx;

  always_comb begin
    state_d = state_q;
    if (LOCK_EN && fire) begin
      state_d = bus.req_last[cand_idx] ? ARB_ST_ARB : ARB_ST_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ARB_ST_ARB;
      ptr_oh_q       <= NUM_REQS'(1) << (NUM_REQS - 1);
      grant_valid_q  <= 1'b0;
      grant_index_q  <= '0;
      grant_onehot_q <= '0;
      grant_last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        grant_valid_q  <= 1'b1;
        grant_index_q  <= cand_idx;
        grant_onehot_q <= cand_oh;
        grant_last_q   <= bus.req_last[cand_idx];
        ptr_oh_q       <= cand_oh;
      end else if (bus.grant_ready) begin
        grant_valid_q  <= 1'b0;
        grant_onehot_q <= '0;
      end
    end
  end

  assign bus.req_ready    = fire ? cand_oh : '0;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_index  = grant_index_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.grant_last   = grant_last_q;
  assign bus.locked       = (state_q == ARB_ST_LOCKED);
endmodule

// File: tb/tb_rv_rr_issue_arbiter.sv
// Directed test of rv_rr_issue_arbiter (8 requesters, lock enabled) and of
// the rv_rr_mask scan for every pointer value.
module tb_rv_rr_issue_arbiter;
  logic       clk;
  logic       reset;
  logic [7:0] mask_oh;
  logic [7:0] mask_out;
  logic [7:0] mask_exp;
  int         n_checks;
  int         n_fail;

  rv_rr_issue_arbiter_if #(.NUM_REQS(8)) bus ();

  rv_rr_issue_arbiter #(.NUM_REQS(8), .LOCK_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rv_rr_mask #(.NUM_REQS(8)) u_mask_chk (
    .onehot_i (mask_oh),
    .mask_o   (mask_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] vld, input logic [7:0] last, input logic gready);
    bus.req_valid   = vld;
    bus.req_last    = last;
    bus.grant_ready = gready;
    #1;
  endtask

  task automatic check_grant(input string tag, input logic vld, input logic [2:0] idx,
                             input logic last, input logic lck);
    check({tag, "_valid"}, 32'(bus.grant_valid), 32'(vld));
    if (vld) begin
      check({tag, "_index"}, 32'(bus.grant_index), 32'(idx));
      check({tag, "_onehot"}, 32'(bus.grant_onehot), 32'(8'd1 << idx));
      check({tag, "_last"}, 32'(bus.grant_last), 32'(last));
    end else begin
      check({tag, "_onehot"}, 32'(bus.grant_onehot), 32'd0);
    end
    check({tag, "_locked"}, 32'(bus.locked), 32'(lck));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mask_oh  = 8'd0;
    bus.req_valid   = 8'h00;
    bus.req_last    = 8'h00;
    bus.grant_ready = 1'b0;

    // standalone mask: bit i set exactly when i > p
    for (int p = 0; p < 8; p++) begin
      mask_oh = 8'd1 << p;
      mask_exp = 8'd0;
      for (int i = 0; i < 8; i++) if (i > p) mask_exp[i] = 1'b1;
      #1;
      check($sformatf("mask_p%0d", p), 32'(mask_out), 32'(mask_exp));
    end

    #1 reset = 1'b0;
    #1;
    check("rst_gvalid", 32'(bus.grant_valid), 32'd0);
    check("rst_gindex", 32'(bus.grant_index), 32'd0);
    check("rst_gonehot", 32'(bus.grant_onehot), 32'd0);
    check("rst_glast", 32'(bus.grant_last), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_rready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();

    // reset priority: index 0 first, then 7
    reset = 1'b1;
    drive(8'h81, 8'hFF, 1'b1);
    check("rp_ready0", 32'(bus.req_ready), 32'h01);
    tick();
    check_grant("rp_g0", 1'b1, 3'd0, 1'b1, 1'b0);
    check("rp_ready7", 32'(bus.req_ready), 32'h80);
    tick();
    check_grant("rp_g7", 1'b1, 3'd7, 1'b1, 1'b0);

    // round-robin over all eight, no bubbles
    drive(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rr_ready%0d", i), 32'(bus.req_ready), 32'(8'd1 << (i % 8)));
      tick();
      check_grant($sformatf("rr_g%0d", i), 1'b1, 3'(i % 8), 1'b1, 1'b0);
    end

    // backpressure with grant 2 pending
    drive(8'h04, 8'hFF, 1'b1);
    tick();
    check_grant("bp_g2", 1'b1, 3'd2, 1'b1, 1'b0);
    drive(8'h0C, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      tick();
      check_grant($sformatf("bp_hold_%0d", i), 1'b1, 3'd2, 1'b1, 1'b0);
    end
    drive(8'h0C, 8'hFF, 1'b1);
    check("bp_ready3", 32'(bus.req_ready), 32'h08);
    tick();
    check_grant("bp_g3", 1'b1, 3'd3, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 1'b1);
    tick();
    check_grant("drain", 1'b0, 3'd0, 1'b0, 1'b0);
    check("drain_index_held", 32'(bus.grant_index), 32'd3);

    // lock basic: 5 sends three beats while 1 waits
    drive(8'h22, 8'h02, 1'b1);
    check("lk_ready_b0", 32'(bus.req_ready), 32'h20);
    tick();
    check_grant("lk_b0", 1'b1, 3'd5, 1'b0, 1'b1);
    check("lk_ready_b1", 32'(bus.req_ready), 32'h20);
    tick();
    check_grant("lk_b1", 1'b1, 3'd5, 1'b0, 1'b1);
    drive(8'h22, 8'h22, 1'b1);
    check("lk_ready_b2", 32'(bus.req_ready), 32'h20);
    tick();
    check_grant("lk_b2", 1'b1, 3'd5, 1'b1, 1'b0);
    drive(8'h02, 8'h02, 1'b1);
    check("lk_ready_r1", 32'(bus.req_ready), 32'h02);
    tick();
    check_grant("lk_r1", 1'b1, 3'd1, 1'b1, 1'b0);

    // lock with gap: 4 locks, drops valid for 2 cycles, 6 must wait
    drive(8'h10, 8'h00, 1'b1);
    check("gap_ready_b0", 32'(bus.req_ready), 32'h10);
    tick();
    check_grant("gap_b0", 1'b1, 3'd4, 1'b0, 1'b1);
    drive(8'h40, 8'h40, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("gap_ready_idle%0d", i), 32'(bus.req_ready), 32'd0);
      tick();
      check_grant($sformatf("gap_idle%0d", i), 1'b0, 3'd0, 1'b0, 1'b1);
    end
    drive(8'h50, 8'h50, 1'b1);
    check("gap_ready_b1", 32'(bus.req_ready), 32'h10);
    tick();
    check_grant("gap_b1", 1'b1, 3'd4, 1'b1, 1'b0);
    drive(8'h40, 8'h40, 1'b1);
    check("gap_ready_r6", 32'(bus.req_ready), 32'h40);
    tick();
    check_grant("gap_r6", 1'b1, 3'd6, 1'b1, 1'b0);

    // async reset in the middle of a locked packet on 3
    drive(8'h08, 8'h00, 1'b1);
    check("ar_ready_b0", 32'(bus.req_ready), 32'h08);
    tick();
    check_grant("ar_b0", 1'b1, 3'd3, 1'b0, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("ar_gvalid", 32'(bus.grant_valid), 32'd0);
    check("ar_gonehot", 32'(bus.grant_onehot), 32'd0);
    check("ar_gindex", 32'(bus.grant_index), 32'd0);
    check("ar_glast", 32'(bus.grant_last), 32'd0);
    check("ar_locked", 32'(bus.locked), 32'd0);
    check("ar_rready", 32'(bus.req_ready), 32'd0);
    tick();
    reset = 1'b1;
    drive(8'h81, 8'hFF, 1'b1);
    check("ar_post_ready", 32'(bus.req_ready), 32'h01);
    tick();
    check_grant("ar_post_g0", 1'b1, 3'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
